mdct_coef_reader: RTL
=====================

# mdct_coef_reader

Drains MDCT coefficients that the forward-MDCT block has written into the shared 512×16 coefficient BRAM. A `start` spike launches a burst of `len` reads from `base_addr`. The block absorbs the BRAM's one-cycle read latency with a small prefetch FIFO and presents the coefficients in address order on a valid/ready stream. Typical consumers are the quantiser/packer or the IMDCT path. Completion is signalled with a single-cycle `intr`, mirroring the writer's interrupt style.

## Interface
- `ADDR_W`, 9: BRAM address width (512 entries).
- `DATA_W`, 16: coefficient width (two's complement).
- `FIFO_DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `clk_in`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle spike; accepted only in IDLE.
- `base_addr`  in  ADDR_W  first BRAM address; sampled on accepted `start`.
- `len`  in  ADDR_W+1  coefficient count, 0..512; sampled on accepted `start`.
- `busy`  out  1  high from the cycle after accepted `start` through the `intr` cycle.
- `intr`  out  1  one-cycle pulse at burst completion.
- `bram_ena`  out  1  BRAM read enable.
- `bram_addra`  out  ADDR_W  BRAM read address.
- `bram_douta`  in  DATA_W  BRAM read data, valid one cycle after `bram_ena`.
- `coef_valid`  out  1  stream data valid.
- `coef_ready`  in  1  consumer ready.
- `coef_data`  out  DATA_W  coefficient.
- `coef_idx`  out  ADDR_W  index within burst (0..len-1).
- `coef_last`  out  1  high with the final coefficient of the burst.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on `start`. `len`/`base_addr` are latched; issue counter, accept counter and in-flight flag are cleared.
- `start` in RUN or DONE is ignored; there is no queuing.
- RUN issue rule: `bram_ena`=1 when issued < len AND fifo_count + inflight < FIFO_DEPTH.
- On each issue: `bram_addra` = base_addr + issued (mod 2^ADDR_W, wraps 511→0); `inflight` is set for one cycle.
- The cycle after an issue, `bram_douta` is written into the FIFO together with its index.
- Stream output is the FIFO head. A transfer is the cycle where `coef_valid && coef_ready`.
- `coef_last` = (head idx == len-1).
- RUN → DONE on the transfer with `coef_last`. DONE lasts exactly one cycle with `intr`=1, then the block returns to IDLE.
- `len`=0: IDLE → RUN → DONE with no BRAM reads and no stream transfers. `intr` fires 2 cycles after `start`.
- `len`=512: the addresses cover the full ring from `base_addr`. `coef_idx` reaches 511.
- `bram_addra` holds its last value when `bram_ena`=0. It is 0 after reset.
- Reset mid-burst discards the FIFO and aborts the burst silently; no `intr`.
- Outputs after reset: `busy`, `intr`, `bram_ena`, `bram_addra`, `coef_valid`, `coef_data`, `coef_idx`, `coef_last` are all 0.
- No arithmetic on the data; coefficients pass bit-exact.

## Timing
- `start` sampled at edge t0. First `bram_ena` is in cycle t0+1 (RUN), with `bram_addra`=base_addr.
- First `coef_valid` is in cycle t0+3 (BRAM latency plus FIFO register).
- With `coef_ready` held high: one coefficient per cycle sustained. The last transfer is at t0+len+2; `intr` is at t0+len+3.
- Backpressure: the issue rule guarantees FIFO never overflows. Data held while `coef_ready`=0 stays stable; `coef_valid` never drops without a transfer.
- FIFO write and read in the same cycle: occupancy is unchanged. Read of the last entry with a simultaneous write must pass through correctly.
- Issue in the same cycle as a FIFO pop: the credit check uses the pre-pop count (conservative).

## Structure
- Shared package `mdct_pkg`:
  - `ADDR_W`, `DATA_W` and `COEF_NUM`=512.
  - State enum `rd_state_t` {IDLE, RUN, DONE}.
  - These are shared with the MDCT writer and the IMDCT path.
- One sub-module, `coef_fifo`: synchronous FIFO, FIFO_DEPTH × (DATA_W+ADDR_W), registered head, async active-low reset, count output.
- The top holds the FSM, counters, credit logic and `coef_last` compare.

## Test plan
- Preload BRAM[k]=k×3; `base_addr`=0, `len`=256, ready high → 256 transfers with data 0,3,…,765 and idx 0..255. `coef_last` on idx 255. `intr` exactly once at t0+259.
- `base_addr`=500, `len`=20 → `bram_addra` 500..511 then 0..7 (wrap). Data order matches. `coef_last` on the 20th transfer.
- `len`=256 with random `coef_ready` (50%) → no data loss or duplication. FIFO count never exceeds 4. Data is stable while stalled.
- `len`=0 → no `bram_ena`, no `coef_valid`. `intr` pulse 2 cycles after `start`. `busy` high for 2 cycles.
- Second `start` pulse mid-burst → ignored; the burst completes normally with one `intr`.
- Assert `rst_n`=0 at transfer 100 of a 256-long burst → all outputs 0 immediately, no `intr`. A new `start` after release runs a clean burst from idx 0.

Source files
------------

// File: rtl/mdct_pkg.sv
// Shared MDCT constants and reader FSM states.
// The MDCT writer and the IMDCT path use these as well.
package mdct_pkg;
    localparam int ADDR_W   = 9;
    localparam int DATA_W   = 16;
    localparam int COEF_NUM = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rd_state_t;
endpackage

// File: rtl/mdct_coef_reader_fifo.sv
// Prefetch FIFO with a registered head entry. A write into an empty FIFO
// goes straight to the head register, and so does a write that arrives while the last entry pops.
module coef_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 25
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wp, rp;
    logic [PW:0]             mem_cnt;
    logic                    pop, head_free, load, bypass, push;

    assign pop       = rd_valid && rd_en;
    assign head_free = !rd_valid || pop;
    assign load      = head_free && (mem_cnt != '0);
    assign bypass    = head_free && (mem_cnt == '0) && wr_en;
    assign push      = wr_en && !bypass;
    assign count     = mem_cnt + {{PW{1'b0}}, rd_valid};

    always_ff @(posedge clk_in) begin
        if (push)
            mem[wp] <= wr_data;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wp       <= '0;
            rp       <= '0;
            mem_cnt  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (load) begin
                rp      <= rp + 1'b1;
                rd_data <= mem[rp];
            end else if (bypass) begin
                rd_data <= wr_data;
            end
            rd_valid <= load || bypass || (rd_valid && !pop);
            case ({push, load})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end
endmodule

// File: rtl/mdct_coef_reader.sv
// Burst reader for the MDCT coefficient BRAM. Each start pulse streams len
// coefficients from base_addr, in address order, on a valid/ready port.
module mdct_coef_reader #(
    parameter int ADDR_W     = mdct_pkg::ADDR_W,
    parameter int DATA_W     = mdct_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              intr,
    output logic              bram_ena,
    output logic [ADDR_W-1:0] bram_addra,
    input  logic [DATA_W-1:0] bram_douta,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic [DATA_W-1:0] coef_data,
    output logic [ADDR_W-1:0] coef_idx,
    output logic              coef_last
);
    import mdct_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = DATA_W + ADDR_W;

    rd_state_t         state, state_nxt;
    logic [ADDR_W:0]   len_q, issued;
    logic [ADDR_W-1:0] base_q, addr_q, inflight_idx, issue_addr;
    logic              inflight, issue, xfer, start_acc;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credit_used;
    logic [EW-1:0]     head;

    assign start_acc   = (state == IDLE) && start;
    assign issue_addr  = base_q + issued[ADDR_W-1:0];
    // Credits use the count before any pop in this cycle. This is conservative, but it can never overflow.
    assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign issue       = (state == RUN) && (issued < len_q) &&
                         (credit_used < (CW+1)'(FIFO_DEPTH));

    assign coef_data = head[DATA_W-1:0];
    assign coef_idx  = head[EW-1:DATA_W];
    assign coef_last = coef_valid && ({1'b0, coef_idx} == len_q - (ADDR_W+1)'(1));
    assign xfer      = coef_valid && coef_ready;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (len_q == '0 || (xfer && coef_last)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        intr       = (state == DONE);
        bram_ena   = issue;
        bram_addra = issue ? issue_addr : addr_q;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            len_q        <= '0;
            base_q       <= '0;
            issued       <= '0;
            addr_q       <= '0;
            inflight     <= 1'b0;
            inflight_idx <= '0;
        end else if (start_acc) begin
            len_q    <= len;
            base_q   <= base_addr;
            issued   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                issued       <= issued + (ADDR_W+1)'(1);
                addr_q       <= issue_addr;
                inflight_idx <= issued[ADDR_W-1:0];
            end
        end
    end

    coef_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .wr_en    (inflight),
        .wr_data  ({inflight_idx, bram_douta}),
        .rd_en    (coef_ready),
        .rd_data  (head),
        .rd_valid (coef_valid),
        .count    (fifo_count)
    );
endmodule
